// File: rtl/motor_sched.sv
// Motor command scheduler: two prioritised requesters share one motor; a dead
// time is inserted before any direction reversal and requester 1 can preempt 0.
module motor_sched #(
  parameter int MS_TICKS = 1000,
  parameter int DEAD_MS  = 20
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] req0_speed,
  input  logic [7:0] req0_dur,
  input  logic [1:0] req1_speed,
  input  logic [7:0] req1_dur,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       abort,
  output logic       busy,
  output logic [1:0] speed,
  output logic [1:0] dbg_state
);

  // Handshake: req is a level sampled only in IDLE; the winner sees a single
  // gnt pulse the cycle after sampling and must drop req by the cycle after
  // that, otherwise it is taken as a fresh request at the next IDLE.

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_BWD} dir_t;

  localparam int TW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(MS_TICKS - 1);
  localparam logic [7:0]    DEAD_LAST = 8'(DEAD_MS - 1);

  function automatic dir_t dir_of(input logic [1:0] s);
    case (s)
      2'b01, 2'b11: dir_of = DIR_FWD;
      2'b10:        dir_of = DIR_BWD;
      default:      dir_of = DIR_NONE;
    endcase
  endfunction

  state_t        state, state_nxt;
  dir_t          last_dir, last_dir_nxt;
  logic          cmd_id, cmd_id_nxt;
  logic [1:0]    cmd_speed, cmd_speed_nxt;
  logic [7:0]    cmd_dur, cmd_dur_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [7:0]    ms, ms_nxt;
  logic [1:0]    gnt_nxt, done_nxt, speed_nxt;
  logic          abort_nxt, busy_nxt;
  logic          sel;
  logic [1:0]    sel_speed;
  logic [7:0]    sel_dur;
  dir_t          sel_dir, cmd_dir;

  assign dbg_state = state;

  always_comb begin
    state_nxt     = state;
    last_dir_nxt  = last_dir;
    cmd_id_nxt    = cmd_id;
    cmd_speed_nxt = cmd_speed;
    cmd_dur_nxt   = cmd_dur;
    tick_nxt      = tick;
    ms_nxt        = ms;
    gnt_nxt       = 2'b00;
    done_nxt      = 2'b00;
    abort_nxt     = 1'b0;
    sel           = req[1];
    sel_speed     = req[1] ? req1_speed : req0_speed;
    sel_dur       = req[1] ? req1_dur : req0_dur;
    sel_dir       = dir_of(sel_speed);
    cmd_dir       = dir_of(cmd_speed);

    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          cmd_id_nxt    = sel;
          cmd_speed_nxt = sel_speed;
          cmd_dur_nxt   = sel_dur;
          gnt_nxt       = sel ? 2'b10 : 2'b01;
          tick_nxt      = '0;
          ms_nxt        = 8'd0;
          if (sel_dur == 8'd0) begin
            state_nxt = S_DONE;
            done_nxt  = sel ? 2'b10 : 2'b01;
          end else if (sel_dir != DIR_NONE && last_dir != DIR_NONE &&
                       sel_dir != last_dir && DEAD_MS > 0) begin
            state_nxt = S_DEAD;
          end else begin
            state_nxt = S_RUN;
            if (sel_dir != DIR_NONE) last_dir_nxt = sel_dir;
          end
        end
      end
      S_DEAD: begin
        if (!cmd_id && req[1]) begin
          state_nxt = S_DONE;
          done_nxt  = 2'b01;
          abort_nxt = 1'b1;
        end else if (tick == TICK_LAST) begin
          tick_nxt = '0;
          if (ms == DEAD_LAST) begin
            state_nxt    = S_RUN;
            ms_nxt       = 8'd0;
            last_dir_nxt = cmd_dir;
          end else begin
            ms_nxt = ms + 8'd1;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      S_RUN: begin
        // Preemption wins even on the final RUN cycle so abort is never lost.
        if (!cmd_id && req[1]) begin
          state_nxt = S_DONE;
          done_nxt  = 2'b01;
          abort_nxt = 1'b1;
        end else if (tick == TICK_LAST) begin
          tick_nxt = '0;
          if (ms == 8'(cmd_dur - 8'd1)) begin
            state_nxt = S_DONE;
            done_nxt  = cmd_id ? 2'b10 : 2'b01;
          end else begin
            ms_nxt = ms + 8'd1;
          end
        end else begin
          tick_nxt = tick + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    speed_nxt = (state_nxt == S_RUN) ? cmd_speed_nxt : 2'b00;
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clkus) begin
    if (rst) begin
      state     <= S_IDLE;
      last_dir  <= DIR_NONE;
      cmd_id    <= 1'b0;
      cmd_speed <= 2'b00;
      cmd_dur   <= 8'd0;
      tick      <= '0;
      ms        <= 8'd0;
      gnt       <= 2'b00;
      done      <= 2'b00;
      abort     <= 1'b0;
      busy      <= 1'b0;
      speed     <= 2'b00;
    end else begin
      state     <= state_nxt;
      last_dir  <= last_dir_nxt;
      cmd_id    <= cmd_id_nxt;
      cmd_speed <= cmd_speed_nxt;
      cmd_dur   <= cmd_dur_nxt;
      tick      <= tick_nxt;
      ms        <= ms_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      abort     <= abort_nxt;
      busy      <= busy_nxt;
      speed     <= speed_nxt;
    end
  end

endmodule
